// File: rtl/serial_frame_rx_if.sv
// serial_frame_rx_if: serial line plus the parallel-word result side of the receiver.
interface serial_frame_rx_if #(
    parameter int DATA_W = 8
);
    logic              rx;
    logic [DATA_W-1:0] data;
    logic              valid;
    logic              frame_err;
    logic              busy;

    modport master (output rx, input data, valid, frame_err, busy);
    modport slave  (input rx, output data, valid, frame_err, busy);
endinterface

// File: rtl/serial_frame_rx.sv
// serial_frame_rx: start/data/stop framed serial receiver with mid-bit sampling.
module serial_frame_rx #(
    parameter int DATA_W = 8,
    parameter int DIV    = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    serial_frame_rx_if.slave  link
);
    localparam int CW = $clog2(DIV);
    localparam int IW = $clog2(DATA_W + 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

    state_t            state_q, state_d;
    logic              sync_q, rx_s_q, rx_prev_q;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [DATA_W-1:0] sh_q, sh_d, data_q, data_d;
    logic              valid_q, valid_d, err_q, err_d, busy_q, busy_d;
    logic              fall, last, half;

    assign fall = !rx_s_q && rx_prev_q;
    assign last = cnt_q == CW'(DIV - 1);
    assign half = cnt_q == CW'(DIV / 2 - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            sync_q    <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
            cnt_q     <= '0;
            idx_q     <= '0;
            sh_q      <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sync_q    <= link.rx;
            rx_s_q    <= sync_q;
            rx_prev_q <= rx_s_q;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            sh_q      <= sh_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        idx_d   = idx_q;
        sh_d    = sh_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (fall) state_d = START;
            end
            START: if (half) begin
                cnt_d   = '0;
                idx_d   = '0;
                state_d = rx_s_q ? IDLE : DATA;
            end
            DATA: if (last) begin
                cnt_d = '0;
                idx_d = idx_q + 1'b1;
                sh_d  = (sh_q & ~(DATA_W'(1) << idx_q)) | (DATA_W'(rx_s_q) << idx_q);
                if (idx_q == IW'(DATA_W - 1)) state_d = STOP;
            end
            STOP: if (last) begin
                cnt_d   = '0;
                state_d = rx_s_q ? IDLE : BREAK;
            end
            BREAK: begin
                cnt_d = '0;
                if (rx_s_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Strobes fire in the cycle after the stop sample; busy mirrors the state being entered.
    always_comb begin
        valid_d = state_q == STOP && last && rx_s_q;
        err_d   = state_q == STOP && last && !rx_s_q;
        data_d  = valid_d ? sh_q : data_q;
        busy_d  = state_d != IDLE;
    end

    assign link.data      = data_q;
    assign link.valid     = valid_q;
    assign link.frame_err = err_q;
    assign link.busy      = busy_q;
endmodule
